ifetch_bp: RTL and testbench

Parametrised instruction-fetch unit with a bimodal branch predictor. It drives the fetch PC to the ICache and pushes {inst, pc, prediction} into the IQueue. JAL is redirected directly. Conditional branches are predicted from a 2-bit-counter BHT. JALR stalls until the writeback/commit stage redirects. Mispredicts and JALR resolution arrive as a single redirect request, which flushes in-flight fetch state.

---
 rtl/ifetch_bp_if.sv | 26 ++
 rtl/ifetch_bp.sv | 77 +++++++
 tb/tb_ifetch_bp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_bp_if.sv
// ifetch_bp_if: fetch-unit bus bundling ICache, IQueue, redirect and BHT-update signals
interface ifetch_bp_if #(parameter int XLEN = 32);
  logic            rdy;
  logic            hit;
  logic [31:0]     inst_in;
  logic [XLEN-1:0] pc;
  logic            full;
  logic            inst_rdy;
  logic [31:0]     inst_out;
  logic [XLEN-1:0] pc_out;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  modport master (
    input  rdy, hit, inst_in, full, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    output pc, inst_rdy, inst_out, pc_out, pred_taken, pred_pc
  );
  modport slave (
    output rdy, hit, inst_in, full, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
    input  pc, inst_rdy, inst_out, pc_out, pred_taken, pred_pc
  );
endinterface

// File: rtl/ifetch_bp.sv
// ifetch_bp: instruction fetch with JAL redirect, bimodal BHT branch prediction and JALR stall
module ifetch_bp #(
  parameter int              XLEN     = 32,
  parameter int              BHT_IDX  = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  ifetch_bp_if.master bus
);
  logic [1:0]         bht [0:(1<<BHT_IDX)-1];
  logic [XLEN-1:0]    pc_r, pc_out_r, pred_pc_r;
  logic [31:0]        inst_out_r;
  logic               inst_rdy_r, pred_taken_r, stall;
  logic [6:0]         op;
  logic               is_jal, is_br, is_jalr, take, fire;
  logic [1:0]         ctr, upd_ctr, upd_nxt;
  logic [BHT_IDX-1:0] rd_idx, wr_idx;
  logic [XLEN-1:0]    j_imm, b_imm, seq_pc, tgt_pc, nxt_pc;
  logic               unused_upd;
  assign op      = bus.inst_in[6:0];
  assign is_jal  = op == 7'b1101111;
  assign is_br   = op == 7'b1100011;
  assign is_jalr = op == 7'b1100111;
  assign j_imm   = XLEN'($signed({bus.inst_in[31], bus.inst_in[19:12], bus.inst_in[20], bus.inst_in[30:21], 1'b0}));
  assign b_imm   = XLEN'($signed({bus.inst_in[31], bus.inst_in[7], bus.inst_in[30:25], bus.inst_in[11:8], 1'b0}));
  assign rd_idx  = pc_r[BHT_IDX+1:2];
  assign wr_idx  = bus.upd_pc[BHT_IDX+1:2];
  assign ctr     = bht[rd_idx];
  assign upd_ctr = bht[wr_idx];
  assign unused_upd = ^{bus.upd_pc[XLEN-1:BHT_IDX+2], bus.upd_pc[1:0]};
  always_comb begin
    seq_pc  = pc_r + XLEN'(4);
    tgt_pc  = pc_r + (is_jal ? j_imm : b_imm);
    take    = is_jal | (is_br & ctr[1]);
    nxt_pc  = is_jalr ? pc_r : take ? tgt_pc : seq_pc;
    fire    = bus.hit & ~stall & ~bus.full;
    upd_nxt = bus.upd_taken ? (upd_ctr == 2'd3 ? 2'd3 : upd_ctr + 2'd1)
                            : (upd_ctr == 2'd0 ? 2'd0 : upd_ctr - 2'd1);
  end
  // BHT read above sees the pre-update value; a same-index write lands at this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      inst_rdy_r   <= 1'b0;
      inst_out_r   <= '0;
      pc_out_r     <= '0;
      pred_taken_r <= 1'b0;
      pred_pc_r    <= '0;
      stall        <= 1'b0;
      for (int i = 0; i < (1 << BHT_IDX); i++) bht[i] <= 2'b01;
    end else if (bus.rdy) begin
      if (bus.upd_valid) bht[wr_idx] <= upd_nxt;
      if (bus.redirect) begin
        pc_r       <= bus.redirect_pc;
        stall      <= 1'b0;
        inst_rdy_r <= 1'b0;
      end else if (!fire) begin
        inst_rdy_r <= 1'b0;
      end else begin
        inst_rdy_r   <= 1'b1;
        inst_out_r   <= bus.inst_in;
        pc_out_r     <= pc_r;
        pc_r         <= nxt_pc;
        pred_taken_r <= take;
        pred_pc_r    <= take ? tgt_pc : seq_pc;
        stall        <= is_jalr;
      end
    end
  end
  assign bus.pc         = pc_r;
  assign bus.inst_rdy   = inst_rdy_r;
  assign bus.inst_out   = inst_out_r;
  assign bus.pc_out     = pc_out_r;
  assign bus.pred_taken = pred_taken_r;
  assign bus.pred_pc    = pred_pc_r;
endmodule

// File: tb/tb_ifetch_bp.sv
// tb_ifetch_bp: directed checks of fetch, prediction, stall, redirect and wrap behaviour
module tb_ifetch_bp;
  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] JAL  = 32'h0100006F;
  localparam logic [31:0] BEQ  = 32'h00000463;
  localparam logic [31:0] JALR = 32'h00008067;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  ifetch_bp_if #(.XLEN(32)) b1 ();
  ifetch_bp_if #(.XLEN(16)) b2 ();
  ifetch_bp #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(b1));
  ifetch_bp #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] ins);
    b1.hit = 1'b1; b1.inst_in = ins;
    tick();
    b1.hit = 1'b0;
  endtask
  task automatic redir(input logic [31:0] a);
    b1.redirect = 1'b1; b1.redirect_pc = a;
    tick();
    b1.redirect = 1'b0;
  endtask
  task automatic upd(input logic t, input int cnt);
    b1.upd_valid = 1'b1; b1.upd_pc = 32'h40; b1.upd_taken = t;
    repeat (cnt) tick();
    b1.upd_valid = 1'b0;
  endtask
  initial begin
    b1.rdy = 1; b1.hit = 0; b1.inst_in = 0; b1.full = 0; b1.redirect = 0; b1.redirect_pc = 0;
    b1.upd_valid = 0; b1.upd_pc = 0; b1.upd_taken = 0;
    b2.rdy = 1; b2.hit = 0; b2.inst_in = 0; b2.full = 0; b2.redirect = 0; b2.redirect_pc = 0;
    b2.upd_valid = 0; b2.upd_pc = 0; b2.upd_taken = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", b1.pc, 0);
    chk("rst_rdy", 32'(b1.inst_rdy), 0);
    chk("rst_inst", b1.inst_out, 0);
    chk("rst_pcout", b1.pc_out, 0);
    chk("rst_ptk", 32'(b1.pred_taken), 0);
    chk("rst_ppc", b1.pred_pc, 0);
    fetch(ADDI);
    chk("addi_rdy", 32'(b1.inst_rdy), 1);
    chk("addi_inst", b1.inst_out, ADDI);
    chk("addi_pcout", b1.pc_out, 0);
    chk("addi_ppc", b1.pred_pc, 4);
    chk("addi_pc", b1.pc, 4);
    tick();
    chk("pulse_end", 32'(b1.inst_rdy), 0);
    redir(32'h10);
    chk("redir_pc", b1.pc, 32'h10);
    fetch(JAL);
    chk("jal_pc", b1.pc, 32'h20);
    chk("jal_ptk", 32'(b1.pred_taken), 1);
    chk("jal_ppc", b1.pred_pc, 32'h20);
    chk("jal_pcout", b1.pc_out, 32'h10);
    fetch(ADDI);
    chk("jal_nostall", b1.pc, 32'h24);
    redir(32'h40);
    fetch(BEQ);
    chk("br0_ptk", 32'(b1.pred_taken), 0);
    chk("br0_pc", b1.pc, 32'h44);
    chk("br0_ppc", b1.pred_pc, 32'h44);
    upd(1'b1, 2);
    redir(32'h40);
    fetch(BEQ);
    chk("br2_ptk", 32'(b1.pred_taken), 1);
    chk("br2_pc", b1.pc, 32'h48);
    chk("br2_ppc", b1.pred_pc, 32'h48);
    upd(1'b1, 1);
    upd(1'b0, 1);
    redir(32'h40);
    fetch(BEQ);
    chk("sat_hi", 32'(b1.pred_taken), 1);
    upd(1'b0, 3);
    upd(1'b1, 1);
    redir(32'h40);
    fetch(BEQ);
    chk("sat_lo", 32'(b1.pred_taken), 0);
    redir(32'h40);
    b1.upd_valid = 1'b1; b1.upd_pc = 32'h40; b1.upd_taken = 1'b1;
    fetch(BEQ);
    b1.upd_valid = 1'b0;
    chk("same_cyc_old", 32'(b1.pred_taken), 0);
    chk("same_cyc_pc", b1.pc, 32'h44);
    redir(32'h40);
    fetch(BEQ);
    chk("same_cyc_new", 32'(b1.pred_taken), 1);
    redir(32'h80);
    fetch(JALR);
    chk("jalr_rdy", 32'(b1.inst_rdy), 1);
    chk("jalr_ptk", 32'(b1.pred_taken), 0);
    chk("jalr_ppc", b1.pred_pc, 32'h84);
    chk("jalr_pc", b1.pc, 32'h80);
    fetch(ADDI);
    chk("stall_rdy", 32'(b1.inst_rdy), 0);
    chk("stall_pc", b1.pc, 32'h80);
    b1.hit = 1'b1; b1.inst_in = ADDI;
    redir(32'h200);
    chk("jalr_redir_pc", b1.pc, 32'h200);
    chk("jalr_redir_rdy", 32'(b1.inst_rdy), 0);
    fetch(ADDI);
    chk("resume_rdy", 32'(b1.inst_rdy), 1);
    chk("resume_pcout", b1.pc_out, 32'h200);
    chk("resume_pc", b1.pc, 32'h204);
    b1.full = 1'b1;
    fetch(ADDI);
    chk("full_rdy", 32'(b1.inst_rdy), 0);
    chk("full_pc", b1.pc, 32'h204);
    redir(32'h300);
    chk("full_redir_pc", b1.pc, 32'h300);
    b1.full = 1'b0;
    fetch(ADDI);
    chk("pre_hold_rdy", 32'(b1.inst_rdy), 1);
    b1.rdy = 1'b0; b1.hit = 1'b1; b1.inst_in = ADDI;
    upd(1'b0, 2);
    chk("hold_rdy", 32'(b1.inst_rdy), 1);
    chk("hold_pc", b1.pc, 32'h304);
    b1.rdy = 1'b1; b1.hit = 1'b0;
    redir(32'h40);
    fetch(BEQ);
    chk("hold_bht", 32'(b1.pred_taken), 1);
    redir(32'h80);
    fetch(JALR);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_pc", b1.pc, 0);
    chk("mid_rst_rdy", 32'(b1.inst_rdy), 0);
    fetch(ADDI);
    chk("mid_rst_nostall", 32'(b1.inst_rdy), 1);
    chk("mid_rst_pc4", b1.pc, 4);
    redir(32'h40);
    fetch(BEQ);
    chk("mid_rst_bht", 32'(b1.pred_taken), 0);
    b2.redirect = 1'b1; b2.redirect_pc = 16'hFFFC;
    tick();
    b2.redirect = 1'b0; b2.hit = 1'b1; b2.inst_in = ADDI;
    tick();
    b2.hit = 1'b0;
    chk("wrap_pc", 32'(b2.pc), 0);
    chk("wrap_pcout", 32'(b2.pc_out), 32'hFFFC);
    chk("wrap_ppc", 32'(b2.pred_pc), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
